// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Holds the FSM state encoding and the counter-width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_full_adder_slice.sv
// One-bit full adder with a registered carry, reused every cycle of a serial add.
// The carry flop is cleared by rst or clr; sum is combinational from a, b and the stored carry.
module serial_full_adder_slice (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_q
);

  logic carry_d;

  assign sum     = a ^ b ^ carry_q;
  assign carry_d = (a & b) | ((a ^ b) & carry_q);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/serial_add_controller.sv
// Sequences a single full-adder slice over WIDTH cycles to add two WIDTH-bit operands,
// LSB first, between a valid/ready input handshake and a valid/ready output handshake.
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output sa_state_t        dbg_state_o
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both 1.
  // in_ready and out_valid are registered and never depend on in_valid/out_ready.

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic accept;
  logic slice_a;
  logic slice_b;
  logic slice_sum;
  logic carry_q;

  assign accept = (state_q == IDLE) && in_valid;

  // Feeding the carry back on both inputs makes the slice hold its carry-out in DONE.
  always_comb begin
    slice_a = 1'b0;
    slice_b = 1'b0;
    case (state_q)
      RUN: begin
        slice_a = a_sr_q[0];
        slice_b = b_sr_q[0];
      end
      DONE: begin
        slice_a = carry_q;
        slice_b = carry_q;
      end
      default: begin
        slice_a = 1'b0;
        slice_b = 1'b0;
      end
    endcase
  end

  serial_full_adder_slice u_slice (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .a       (slice_a),
    .b       (slice_b),
    .sum     (slice_sum),
    .carry_q (carry_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q     <= in_a;
            b_sr_q     <= in_b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= {slice_sum, sum_sr_q[WIDTH-1:1]};
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = {carry_q, sum_sr_q};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_controller.sv
// Self-checking bench for serial_add_controller: directed vectors plus randomized traffic
// checked every cycle against a transaction-level model (accept time, expected-sum queue).
module tb_serial_add_controller;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  sa_state_t    dbg_state;

  serial_add_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .dbg_state_o (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: one operation in flight, result due WIDTH edges after acceptance
  logic [W:0] exp_q[$];
  bit         m_busy     = 1'b0;
  bit         m_rst_last = 1'b0;
  int         m_acc      = 0;
  int         cyc        = 0;
  int         n_done     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: update the model at the posedge from the driven inputs, check at the negedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    m_rst_last = rst;
    if (rst) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else if (!m_busy && in_valid) begin
      m_busy = 1'b1;
      m_acc  = cyc;
      exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
    end else if (m_busy && (cyc - 1 >= m_acc + W) && out_ready) begin
      m_busy = 1'b0;
      void'(exp_q.pop_front());
      n_done++;
    end
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_busy && (cyc >= m_acc + W)});
    if (m_busy && (cyc >= m_acc + W) && exp_q.size() > 0)
      check("out_sum", {23'd0, out_sum}, {23'd0, exp_q[0]});
    if (m_rst_last)
      check("rst_sum", {23'd0, out_sum}, 32'd0);
  endtask

  // driver: one directed operation with a backpressure hold of `hold` cycles in DONE
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input logic [W:0] exp);
    int lat;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3 * W) begin
      tick();
      lat++;
    end
    check("latency", lat, W);
    check("dir_sum", {23'd0, out_sum}, {23'd0, exp});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_sum", {23'd0, out_sum}, {23'd0, exp});
      check("bp_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int start_done;
    int budget;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("reset_flags", {30'd0, out_valid, in_ready}, 32'd1);
    check("reset_sum", {23'd0, out_sum}, 32'd0);

    run_op(8'hFF, 8'h01, 0, 9'h100);
    run_op(8'hA5, 8'h5A, 1, 9'h0FF);
    run_op(8'h00, 8'h00, 0, 9'h000);
    run_op(8'hFF, 8'hFF, 0, 9'h1FE);
    run_op(8'h01, 8'h00, 0, 9'h001);
    run_op(8'h80, 8'h80, 5, 9'h100);

    // abort mid-RUN: rst at acceptance + 4
    in_valid = 1'b1;
    in_a     = 8'hF0;
    in_b     = 8'h33;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", {30'd0, out_valid, in_ready}, 32'd1);
    check("abort_sum", {23'd0, out_sum}, 32'd0);
    tick();
    run_op(8'h12, 8'h34, 0, 9'h046);

    // randomized traffic with gaps on both handshakes
    start_done = n_done;
    budget     = 0;
    while ((n_done - start_done) < 1000 && budget < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      budget++;
    end
    check("rand_ops", n_done - start_done, 1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
